// File: rtl/vga_frame_scanner_pkg.sv
// vga_frame_scanner_pkg: screen geometry, source latency and scanner state encoding
// shared by the frame scanner and its delay line.
package vga_frame_scanner_pkg;
    localparam int SCREEN_W    = 320;
    localparam int SCREEN_H    = 240;
    localparam int SRC_LATENCY = 3;
    localparam int X_W         = 9;
    localparam int Y_W         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SCAN  = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } scan_state_e;
endpackage

// File: rtl/vga_frame_scanner_coord_delay_line.sv
// coord_delay_line: DEPTH-stage shift of {valid,data}; every stage clears on reset so no
// stale coordinate can surface as a plot after Resetn.
module coord_delay_line #(
    parameter int DEPTH = 3,
    parameter int W     = 17
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic [DEPTH-1:0] v_q;
    logic [W-1:0]     d_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        end else begin
            v_q[0] <= valid_i;
            d_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign valid_o = v_q[DEPTH-1];
    assign data_o  = d_q[DEPTH-1];
endmodule

// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: raster coordinate generator for a fixed-latency pixel source, turning
// its delayed colour answers into aligned plot writes for the VGA adapter.
module vga_frame_scanner
    import vga_frame_scanner_pkg::*;
#(
    parameter int WIDTH   = SCREEN_W,
    parameter int HEIGHT  = SCREEN_H,
    parameter int LATENCY = SRC_LATENCY,
    parameter int XW      = X_W,
    parameter int YW      = Y_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          continuous_i,
    output logic          enable_o,
    output logic [XW-1:0] vga_x_o,
    output logic [YW-1:0] vga_y_o,
    input  logic          vga_col_i,
    output logic          plot_o,
    output logic [XW-1:0] plot_x_o,
    output logic [YW-1:0] plot_y_o,
    output logic          plot_col_o,
    output logic          busy_o,
    output logic          frame_done_o
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    scan_state_e   state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_x, last_y, tail_v;
    logic [XW+YW-1:0] tail_d;

    assign last_x = x_q == XW'(WIDTH - 1);
    assign last_y = y_q == YW'(HEIGHT - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  state_d = (start_i || continuous_i) ? SCAN : IDLE;
            SCAN: begin
                x_d = last_x ? '0 : x_q + XW'(1);
                if (last_x) y_d = last_y ? '0 : y_q + YW'(1);
                if (last_x && last_y) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(LATENCY - 1)) state_d = DONE;
            end
            DONE:  state_d = continuous_i ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    coord_delay_line #(.DEPTH(LATENCY), .W(XW + YW)) u_delay (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .valid_i(state_q == SCAN),
        .data_i ({x_q, y_q}),
        .valid_o(tail_v),
        .data_o (tail_d)
    );

    assign enable_o     = (state_q == SCAN) || (state_q == DRAIN);
    assign busy_o       = enable_o;
    assign frame_done_o = state_q == DONE;
    assign vga_x_o      = x_q;
    assign vga_y_o      = y_q;
    assign plot_o       = tail_v;
    assign plot_x_o     = tail_d[XW+YW-1:YW];
    assign plot_y_o     = tail_d[YW-1:0];
    // Source colour is only meaningful when the tail holds a live coordinate.
    assign plot_col_o   = tail_v & vga_col_i;
endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: directed checks of a full 320x240 frame and of a 4x2 latency-1
// instance covering continuous mode, ignored starts and reset during drain.
module tb_vga_frame_scanner;
    logic clk = 0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       rst_a = 0, start_a = 0, cont_a = 0, en_a, plot_a, pcol_a, busy_a, done_a, col_a;
    logic [8:0] vx_a, px_a;
    logic [7:0] vy_a, py_a;
    logic       rst_b = 0, start_b = 0, cont_b = 0, en_b, plot_b, pcol_b, busy_b, done_b, col_b;
    logic [8:0] vx_b, px_b;
    logic [7:0] vy_b, py_b;
    logic       sa0, sa1;

    vga_frame_scanner u_a (
        .clk_i(clk), .rst_ni(rst_a), .start_i(start_a), .continuous_i(cont_a),
        .enable_o(en_a), .vga_x_o(vx_a), .vga_y_o(vy_a), .vga_col_i(col_a),
        .plot_o(plot_a), .plot_x_o(px_a), .plot_y_o(py_a), .plot_col_o(pcol_a),
        .busy_o(busy_a), .frame_done_o(done_a)
    );

    vga_frame_scanner #(.WIDTH(4), .HEIGHT(2), .LATENCY(1)) u_b (
        .clk_i(clk), .rst_ni(rst_b), .start_i(start_b), .continuous_i(cont_b),
        .enable_o(en_b), .vga_x_o(vx_b), .vga_y_o(vy_b), .vga_col_i(col_b),
        .plot_o(plot_b), .plot_x_o(px_b), .plot_y_o(py_b), .plot_col_o(pcol_b),
        .busy_o(busy_b), .frame_done_o(done_b)
    );

    // Stub pixel sources: registered (x^y)[0], three stages for A and one for B.
    always_ff @(posedge clk) begin
        sa0   <= vx_a[0] ^ vy_a[0];
        sa1   <= sa0;
        col_a <= sa1;
        col_b <= vx_b[0] ^ vy_b[0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_b(input int start_at, input int clr_at, output int plots,
                         output int first_at, output int done_at);
        int ex, ey;
        ex = 0; ey = 0; plots = 0; first_at = -1; done_at = -1;
        for (int i = 0; i < 40 && done_at < 0; i++) begin
            @(negedge clk);
            if (i == start_at) start_b = 1;
            if (i == start_at + 1) start_b = 0;
            if (i == clr_at) cont_b = 0;
            if (i == 0) begin
                chk("b_entry_x", vx_b, 0);
                chk("b_entry_y", vy_b, 0);
                chk("b_entry_busy", busy_b, 1);
            end
            if (i == 3) chk("b_issue_3_0", {vx_b, vy_b}, {9'd3, 8'd0});
            if (i == 4) chk("b_issue_0_1", {vx_b, vy_b}, {9'd0, 8'd1});
            if (plot_b) begin
                if (first_at < 0) first_at = i;
                chk("b_plot_xy", {px_b, py_b}, {ex[8:0], ey[7:0]});
                chk("b_plot_col", pcol_b, ex[0] ^ ey[0]);
                plots++;
                if (ex == 3) begin ex = 0; ey++; end else ex++;
            end
            if (done_b) done_at = i;
        end
    endtask

    initial begin
        int plots, first_at, last_at, done_at, ex, ey, n;
        @(negedge clk);
        chk("a_rst_outs", {en_a, plot_a, busy_a, done_a, pcol_a}, 0);
        chk("a_rst_xy", {vx_a, vy_a, px_a, py_a}, 0);
        chk("b_rst_outs", {en_b, plot_b, busy_b, done_b, pcol_b}, 0);
        rst_a = 1; rst_b = 1;
        repeat (3) @(negedge clk);
        chk("a_idle_busy", {busy_a, en_a, plot_a}, 0);

        // Full-size frame with a stray Start in the middle of SCAN.
        start_a = 1;
        @(posedge clk); #1 start_a = 0;
        ex = 0; ey = 0; plots = 0; first_at = -1; last_at = -1; done_at = -1;
        for (int i = 0; i < 77000 && done_at < 0; i++) begin
            @(negedge clk);
            if (i == 1000) start_a = 1;
            if (i == 1001) start_a = 0;
            if (i == 0) chk("a_entry", {vx_a, vy_a, busy_a, en_a}, {9'd0, 8'd0, 1'b1, 1'b1});
            if (i == 319) chk("a_issue_319_0", {vx_a, vy_a}, {9'd319, 8'd0});
            if (i == 320) chk("a_issue_0_1", {vx_a, vy_a}, {9'd0, 8'd1});
            if (i == 322) chk("a_plot_319_0", {plot_a, px_a, py_a}, {1'b1, 9'd319, 8'd0});
            if (i == 323) chk("a_plot_0_1", {plot_a, px_a, py_a}, {1'b1, 9'd0, 8'd1});
            if (plot_a) begin
                if (first_at < 0) first_at = i;
                last_at = i;
                chk("a_plot_xy", {px_a, py_a}, {ex[8:0], ey[7:0]});
                chk("a_plot_col", pcol_a, ex[0] ^ ey[0]);
                plots++;
                if (ex == 319) begin ex = 0; ey++; end else ex++;
            end
            if (done_a) done_at = i;
        end
        chk("a_plots", plots, 76800);
        chk("a_first_plot", first_at, 3);
        chk("a_last_plot", last_at, 76802);
        chk("a_done_cycle", done_at, 76803);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n += int'(plot_a) + int'(done_a) + int'(busy_a);
        end
        chk("a_quiet_after", n, 0);

        // Small instance: single frame from Start and Continuous together.
        start_b = 1; cont_b = 1;
        @(posedge clk); #1 start_b = 0; cont_b = 0;
        run_b(-10, -10, plots, first_at, done_at);
        chk("b_plots", plots, 8);
        chk("b_first_plot", first_at, 1);
        chk("b_done_cycle", done_at, 9);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n += int'(plot_b) + int'(done_b) + int'(busy_b);
        end
        chk("b_single_start", n, 0);

        // Start during SCAN is ignored.
        start_b = 1;
        @(posedge clk); #1 start_b = 0;
        run_b(2, -10, plots, first_at, done_at);
        chk("b_ign_plots", plots, 8);
        chk("b_ign_done", done_at, 9);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n += int'(done_b) + int'(busy_b);
        end
        chk("b_ign_no_restart", n, 0);

        // Continuous: back-to-back frames, cleared during the second.
        cont_b = 1;
        @(posedge clk); #1;
        run_b(-10, -10, plots, first_at, done_at);
        chk("b_cont1_done", done_at, 9);
        run_b(-10, 4, plots, first_at, done_at);
        chk("b_cont2_plots", plots, 8);
        chk("b_cont2_done", done_at, 9);
        @(negedge clk);
        chk("b_cont_idle", {busy_b, en_b}, 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n += int'(plot_b) + int'(busy_b);
        end
        chk("b_cont_quiet", n, 0);

        // Reset asserted during the single DRAIN cycle.
        start_b = 1;
        @(posedge clk); #1 start_b = 0;
        repeat (9) @(negedge clk);
        chk("b_drain_plot", {plot_b, px_b, py_b, busy_b}, {1'b1, 9'd3, 8'd1, 1'b1});
        rst_b = 0;
        #1 chk("b_async_drop", {plot_b, busy_b, en_b}, 0);
        @(negedge clk) rst_b = 1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n += int'(plot_b) + int'(busy_b) + int'(done_b);
        end
        chk("b_post_reset_quiet", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
